// File: rtl/ws_led_fifo.sv
// ws_led_fifo: iomem-mapped LED command FIFO that feeds the ws2812 driver at a fixed pace.
// Define WS_LED_FIFO_BRIGHTNESS_EN to add the BRIGHT register and per-channel colour scaling.
module ws_led_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h0400_0000,
    parameter int          DEPTH     = 8,
    parameter int          DRAIN_GAP = 64,
    parameter int          NUM_LEDS  = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [7:0]  led_num,
    output logic [23:0] led_rgb_data,
    output logic        led_write
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(DRAIN_GAP);
    localparam logic [8:0] NUM_LIM = 9'(NUM_LEDS);

    typedef enum logic {IDLE, GAP} state_t;

    state_t        state, state_next;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [GW-1:0] gap_cnt;
    logic          overflow, range_err, ovf_next, rng_next;
    logic [31:0]   off, rdata_next, status_word, bright_rd, head;
    logic [1:0]    sel;
    logic          in_win, access, wr, push_req, num_bad, push, pop, full, empty, clr_wr;
    logic [23:0]   issue_rgb;

    // Bus handshake: a request is taken when valid && !ready && the address is in
    // the window; ready then pulses for one cycle carrying rdata, otherwise rdata is 0.
    assign off      = iomem_addr - BASE_ADDR;
    assign in_win   = off < 32'd12;
    assign sel      = off[3:2];
    assign access   = iomem_valid && !iomem_ready && in_win;
    assign wr       = access && (iomem_wstrb != 4'h0);
    assign push_req = wr && (sel == 2'd0) && (iomem_wstrb == 4'hF);
    assign clr_wr   = wr && (sel == 2'd1) && iomem_wstrb[1];
    assign num_bad  = {1'b0, iomem_wdata[7:0]} >= NUM_LIM;
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign push     = push_req && !full && !num_bad;
    assign head     = mem[rd_ptr];

    // Flag updates: a set in the same cycle as a clear wins.
    assign ovf_next   = (push_req && full) || (overflow && !(clr_wr && iomem_wdata[10]));
    assign rng_next   = (push_req && num_bad) || (range_err && !(clr_wr && iomem_wdata[11]));
    assign count_next = count + CW'(push) - CW'(pop);

`ifdef WS_LED_FIFO_BRIGHTNESS_EN
    logic [7:0] bright;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bright <= 8'hFF;
        end else if (wr && (sel == 2'd2) && iomem_wstrb[0]) begin
            bright <= iomem_wdata[7:0];
        end
    end

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'd0, c} * ({9'd0, b} + 17'd1);
        return 8'(p >> 8);
    endfunction

    assign issue_rgb = {scale(head[31:24], bright), scale(head[23:16], bright), scale(head[15:8], bright)};
    assign bright_rd = {24'd0, bright};
`else
    assign issue_rgb = head[31:8];
    assign bright_rd = 32'd0;
`endif

    // STATUS reflects this edge's push/pop so a read during a drain sees the post-pop count.
    always_comb begin
        status_word            = 32'd0;
        status_word[CW-1:0]    = count_next;
        status_word[8]         = count_next == '0;
        status_word[9]         = count_next == CW'(DEPTH);
        status_word[10]        = ovf_next;
        status_word[11]        = rng_next;
        status_word[12]        = state_next != IDLE;
        case (sel)
            2'd1:    rdata_next = status_word;
            2'd2:    rdata_next = bright_rd;
            default: rdata_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'd0;
        end else begin
            iomem_ready <= access;
            iomem_rdata <= access ? rdata_next : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= iomem_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            overflow  <= ovf_next;
            range_err <= rng_next;
        end
    end

    // GAP holds for DRAIN_GAP-1 edges so pulses land exactly DRAIN_GAP cycles apart.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(DRAIN_GAP - 2)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_num      <= 8'd0;
            led_rgb_data <= 24'd0;
            led_write    <= 1'b0;
        end else begin
            led_write <= pop;
            if (pop) begin
                led_num      <= head[7:0];
                led_rgb_data <= issue_rgb;
            end
        end
    end
endmodule

// File: tb/tb_ws_led_fifo.sv
// Bench for ws_led_fifo: randomized pushes checked against a queue model of FIFO order,
// pulse pacing, status flags and optional brightness scaling.
module tb_ws_led_fifo;
    localparam logic [31:0] BASE     = 32'h0400_0000;
    localparam int          GAP      = 64;
    localparam int          NUM_LEDS = 7;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic [7:0]  led_num;
    logic [23:0] led_rgb_data;
    logic        led_write;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_miss = 0;
    logic [31:0] exp_q[$];
    int          cap_cyc[$];
    logic [31:0] cap_ent[$];

    ws_led_fifo dut (
        .clk          (clk),
        .resetn       (resetn),
        .iomem_valid  (iomem_valid),
        .iomem_ready  (iomem_ready),
        .iomem_wstrb  (iomem_wstrb),
        .iomem_addr   (iomem_addr),
        .iomem_wdata  (iomem_wdata),
        .iomem_rdata  (iomem_rdata),
        .led_num      (led_num),
        .led_rgb_data (led_rgb_data),
        .led_write    (led_write)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn && led_write) begin
            cap_cyc.push_back(cyc);
            cap_ent.push_back({led_rgb_data, led_num});
        end
    end

    // Colour the driver should see for a queued rgb at brightness b.
    function automatic logic [23:0] exp_colour(input logic [23:0] rgb, input int b);
        logic [23:0] res;
`ifdef WS_LED_FIFO_BRIGHTNESS_EN
        for (int k = 0; k < 3; k++) begin
            res[8*k +: 8] = 8'((int'(rgb[8*k +: 8]) * (b + 1)) / 256);
        end
`else
        res = rgb;
        if (b < 0) res = 24'd0;
`endif
        return res;
    endfunction

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output int ack_cyc);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = strb;
        rdata       = 32'hDEAD_BEEF;
        ack_cyc     = -1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) begin
                rdata   = iomem_rdata;
                ack_cyc = cyc;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (ack_cyc < 0) ack_miss++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int          ac;
        #1;
        checks++;
        if ({iomem_ready, iomem_rdata, led_num, led_rgb_data, led_write} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {iomem_ready, iomem_rdata, led_num, led_rgb_data, led_write});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        ack_miss = 0;
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h100) begin errors++; $display("FAIL reset_status got %h exp %h", rd, 32'h100); end
        bus_xfer(BASE + 32'h8, 32'd0, 4'h0, rd, ac);
`ifdef WS_LED_FIFO_BRIGHTNESS_EN
        checks++;
        if (rd !== 32'hFF) begin errors++; $display("FAIL reset_bright got %h exp %h", rd, 32'hFF); end
`else
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_bright got %h exp %h", rd, 32'h0); end
`endif
        bus_xfer(BASE, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL data_read got %h exp 0", rd); end
        checks++;
        if (ack_miss !== 0) begin errors++; $display("FAIL reset_acks got %0d exp 0", ack_miss); end
    endtask

    task automatic test_single();
        logic [31:0] rd;
        int          ac;
        ack_miss = 0;
        cap_cyc.delete();
        cap_ent.delete();
        bus_xfer(BASE, 32'h1122_3303, 4'hF, rd, ac);
        repeat (5) @(posedge clk);
        checks++;
        if (cap_ent.size() !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", cap_ent.size()); end
        if (cap_ent.size() > 0) begin
            checks++;
            if (cap_ent[0] !== 32'h1122_3303) begin errors++; $display("FAIL single_entry got %h exp %h", cap_ent[0], 32'h1122_3303); end
            checks++;
            if (cap_cyc[0] - ac !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", cap_cyc[0] - ac); end
        end
        checks++;
        if (ack_miss !== 0) begin errors++; $display("FAIL single_ack got %0d exp 0", ack_miss); end
        repeat (GAP) @(posedge clk);
    endtask

    task automatic test_burst();
        logic [31:0] rd, w, r;
        int          ac, first_ac;
        ack_miss = 0;
        exp_q.delete();
        cap_cyc.delete();
        cap_ent.delete();
        first_ac = 0;
        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            w = {r[31:8], 8'($urandom_range(0, NUM_LEDS - 1))};
            exp_q.push_back({exp_colour(w[31:8], 255), w[7:0]});
            bus_xfer(BASE, w, 4'hF, rd, ac);
            if (i == 0) first_ac = ac;
        end
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h1007) begin errors++; $display("FAIL burst_mid_status got %h exp %h", rd, 32'h1007); end
        repeat (8 * GAP + 20) @(posedge clk);
        checks++;
        if (cap_ent.size() !== 8) begin errors++; $display("FAIL burst_pulses got %0d exp 8", cap_ent.size()); end
        if (cap_cyc.size() > 0) begin
            checks++;
            if (cap_cyc[0] - first_ac !== 1) begin errors++; $display("FAIL burst_latency got %0d exp 1", cap_cyc[0] - first_ac); end
        end
        for (int i = 0; i < cap_ent.size() && exp_q.size() > 0; i++) begin
            w = exp_q.pop_front();
            checks++;
            if (cap_ent[i] !== w) begin errors++; $display("FAIL burst_entry%0d got %h exp %h", i, cap_ent[i], w); end
            if (i > 0) begin
                checks++;
                if (cap_cyc[i] - cap_cyc[i-1] !== GAP) begin
                    errors++; $display("FAIL burst_spacing%0d got %0d exp %0d", i, cap_cyc[i] - cap_cyc[i-1], GAP);
                end
            end
        end
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h100) begin errors++; $display("FAIL burst_end_status got %h exp %h", rd, 32'h100); end
        checks++;
        if (ack_miss !== 0) begin errors++; $display("FAIL burst_acks got %0d exp 0", ack_miss); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, w, r;
        int          ac;
        ack_miss = 0;
        exp_q.delete();
        cap_cyc.delete();
        cap_ent.delete();
        // The first entry issues at once and opens a gap; the next nine arrive inside it.
        for (int i = 0; i < 10; i++) begin
            r = $urandom();
            w = {r[31:8], 8'($urandom_range(0, NUM_LEDS - 1))};
            if (i < 9) exp_q.push_back(w);
            bus_xfer(BASE, w, 4'hF, rd, ac);
        end
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h1608) begin errors++; $display("FAIL ovf_status got %h exp %h", rd, 32'h1608); end
        bus_xfer(BASE + 32'h4, 32'h400, 4'hF, rd, ac);
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h1208) begin errors++; $display("FAIL ovf_clear got %h exp %h", rd, 32'h1208); end
        repeat (9 * GAP + 20) @(posedge clk);
        checks++;
        if (cap_ent.size() !== 9) begin errors++; $display("FAIL ovf_pulses got %0d exp 9", cap_ent.size()); end
        for (int i = 0; i < cap_ent.size() && exp_q.size() > 0; i++) begin
            w = exp_q.pop_front();
            checks++;
            if (cap_ent[i] !== w) begin errors++; $display("FAIL ovf_entry%0d got %h exp %h", i, cap_ent[i], w); end
        end
        checks++;
        if (ack_miss !== 0) begin errors++; $display("FAIL ovf_acks got %0d exp 0", ack_miss); end
    endtask

    task automatic test_range_strobe();
        logic [31:0] rd, r;
        int          ac;
        ack_miss = 0;
        cap_ent.delete();
        cap_cyc.delete();
        r = $urandom();
        bus_xfer(BASE, {r[31:8], 8'($urandom_range(NUM_LEDS, 255))}, 4'hF, rd, ac);
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h900) begin errors++; $display("FAIL range_status got %h exp %h", rd, 32'h900); end
        bus_xfer(BASE + 32'h4, 32'h800, 4'hF, rd, ac);
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h100) begin errors++; $display("FAIL range_clear got %h exp %h", rd, 32'h100); end
        bus_xfer(BASE, 32'h00AB_CD02, 4'h3, rd, ac);
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h100) begin errors++; $display("FAIL strobe_status got %h exp %h", rd, 32'h100); end
        checks++;
        if (ack_miss !== 0) begin errors++; $display("FAIL range_acks got %0d exp 0", ack_miss); end
        bus_xfer(BASE + 32'hC, 32'h0000_0001, 4'hF, rd, ac);
        bus_xfer(BASE + 32'h100, 32'd0, 4'h0, rd, ac);
        bus_xfer(BASE - 32'h4, 32'h0000_0001, 4'hF, rd, ac);
        checks++;
        if (ack_miss !== 3) begin errors++; $display("FAIL outside_window_acks got %0d exp 3", ack_miss); end
        repeat (GAP + 4) @(posedge clk);
        checks++;
        if (cap_ent.size() !== 0) begin errors++; $display("FAIL range_pulses got %0d exp 0", cap_ent.size()); end
    endtask

    task automatic test_brightness();
        logic [31:0] rd, w, r;
        int          ac, b;
        ack_miss = 0;
        exp_q.delete();
        cap_ent.delete();
        cap_cyc.delete();
        bus_xfer(BASE + 32'h8, 32'h7F, 4'hF, rd, ac);
        bus_xfer(BASE + 32'h8, 32'd0, 4'h0, rd, ac);
`ifdef WS_LED_FIFO_BRIGHTNESS_EN
        b = 127;
        checks++;
        if (rd !== 32'h7F) begin errors++; $display("FAIL bright_read got %h exp %h", rd, 32'h7F); end
        exp_q.push_back({24'h7F4001, 8'h05});
`else
        b = 255;
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL bright_read got %h exp 0", rd); end
        exp_q.push_back({24'hFF8002, 8'h05});
`endif
        bus_xfer(BASE, 32'hFF80_0205, 4'hF, rd, ac);
        repeat (GAP) @(posedge clk);
        b = $urandom_range(0, 255);
        bus_xfer(BASE + 32'h8, b, 4'hF, rd, ac);
`ifndef WS_LED_FIFO_BRIGHTNESS_EN
        b = 255;
`endif
        for (int i = 0; i < 3; i++) begin
            r = $urandom();
            w = {r[31:8], 8'($urandom_range(0, NUM_LEDS - 1))};
            exp_q.push_back({exp_colour(w[31:8], b), w[7:0]});
            bus_xfer(BASE, w, 4'hF, rd, ac);
        end
        repeat (3 * GAP + 10) @(posedge clk);
        checks++;
        if (cap_ent.size() !== 4) begin errors++; $display("FAIL bright_pulses got %0d exp 4", cap_ent.size()); end
        for (int i = 0; i < cap_ent.size() && exp_q.size() > 0; i++) begin
            w = exp_q.pop_front();
            checks++;
            if (cap_ent[i] !== w) begin errors++; $display("FAIL bright_entry%0d got %h exp %h", i, cap_ent[i], w); end
        end
        bus_xfer(BASE + 32'h8, 32'hFF, 4'hF, rd, ac);
        checks++;
        if (ack_miss !== 0) begin errors++; $display("FAIL bright_acks got %0d exp 0", ack_miss); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          ac;
        bit          seen;
        ack_miss = 0;
        for (int i = 0; i < 3; i++) bus_xfer(BASE, {$urandom_range(0, 24'hFFFFFF), 8'(i)}, 4'hF, rd, ac);
        seen = 1'b0;
        for (int i = 0; i < 2 * GAP + 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (led_write) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_pulse_seen got 0 exp 1"); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({iomem_ready, iomem_rdata, led_num, led_rgb_data, led_write} !== 66'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h exp 0", {iomem_ready, iomem_rdata, led_num, led_rgb_data, led_write});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cap_ent.delete();
        cap_cyc.delete();
        bus_xfer(BASE + 32'h4, 32'd0, 4'h0, rd, ac);
        checks++;
        if (rd !== 32'h100) begin errors++; $display("FAIL mid_reset_status got %h exp %h", rd, 32'h100); end
        repeat (GAP + 10) @(posedge clk);
        checks++;
        if (cap_ent.size() !== 0) begin errors++; $display("FAIL mid_reset_pulses got %0d exp 0", cap_ent.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_range_strobe();
        test_brightness();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
